// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: widths, reset PC and fetch FSM encodings.
// Imported by the fetch controller and its slot register.
package if_fetch_ctrl_pkg;
   localparam int IF_XLEN = 32;
   localparam int INSTR_WIDTH = 32;
   localparam logic [31:0] IF_RESET_PC = 32'h8000_0000;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_JWAIT = 3'd3;
   localparam logic [2:0] ST_DROP  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      REQ   = ST_REQ,
      WAIT  = ST_WAIT,
      JWAIT = ST_JWAIT,
      DROP  = ST_DROP
   } fetch_state_e;

   // Static prediction: jal always taken, conditional branch taken only when backward.
   function automatic logic predict_taken(input logic jal, input logic jalr,
                                          input logic branch, input logic imm_neg);
      return !jalr && (jal || (branch && imm_neg));
   endfunction
endpackage

// File: rtl/if_fetch_ctrl_slot.sv
// One-entry IF->ID holding register with load, consume and flush.
// Flush wins over load; a load in the same cycle as a consume keeps the slot full.
module if_slot
   import if_fetch_ctrl_pkg::*;
#(
   parameter int XLEN = IF_XLEN
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   load,
   input  logic                   flush,
   input  logic                   consume,
   input  logic [INSTR_WIDTH-1:0] ld_instr,
   input  logic [XLEN-1:0]        ld_pc,
   input  logic                   ld_pred,
   output logic                   valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [XLEN-1:0]        pc,
   output logic                   pred_taken
);
   logic                   valid_reg;
   logic [INSTR_WIDTH-1:0] instr_reg;
   logic [XLEN-1:0]        pc_reg;
   logic                   pred_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         valid_reg <= 1'b0;
         instr_reg <= '0;
         pc_reg    <= '0;
         pred_reg  <= 1'b0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
         instr_reg <= ld_instr;
         pc_reg    <= ld_pc;
         pred_reg  <= ld_pred;
      end else if (consume) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid      = valid_reg;
   assign instr      = instr_reg;
   assign pc         = pc_reg;
   assign pred_taken = pred_reg;
endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: one outstanding imem request, static next-PC prediction,
// EX redirects with in-flight response dropping, and a one-entry slot toward ID.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int              XLEN     = IF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   imem_req_valid_o,
   input  logic                   imem_req_ready_i,
   output logic [XLEN-1:0]        imem_req_addr_o,
   input  logic                   imem_rsp_valid_i,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_instr_i,
   output logic [INSTR_WIDTH-1:0] mdec_instr_o,
   input  logic                   mdec_jal_i,
   input  logic                   mdec_jalr_i,
   input  logic                   mdec_branch_i,
   input  logic [XLEN-1:0]        mdec_imm_i,
   input  logic                   ex_redirect_i,
   input  logic [XLEN-1:0]        ex_redirect_pc_i,
   input  logic                   id_ready_i,
   output logic                   if_valid_o,
   output logic [INSTR_WIDTH-1:0] if_instr_o,
   output logic [XLEN-1:0]        if_pc_o,
   output logic                   if_pred_taken_o
);
   fetch_state_e    state_reg, state_next;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic            slot_free;
   logic            req_fire;
   logic            rsp_load;
   logic            rsp_pred;

   // A new request may only go out if its response can land in the slot.
   assign slot_free        = !if_valid_o || id_ready_i;
   assign imem_req_valid_o = (state_reg == REQ) && slot_free;
   assign imem_req_addr_o  = fetch_pc_reg;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;
   assign mdec_instr_o     = imem_rsp_instr_i;
   assign rsp_pred         = predict_taken(mdec_jal_i, mdec_jalr_i, mdec_branch_i,
                                           mdec_imm_i[XLEN-1]);
   assign rsp_load         = (state_reg == WAIT) && imem_rsp_valid_i && !ex_redirect_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      case (state_reg)
         IDLE:    state_next = REQ;
         REQ:     if (req_fire) state_next = WAIT;
         WAIT: begin
            if (imem_rsp_valid_i) begin
               if (mdec_jalr_i) begin
                  state_next = JWAIT;
               end else begin
                  state_next    = REQ;
                  fetch_pc_next = rsp_pred ? fetch_pc_reg + mdec_imm_i
                                           : fetch_pc_reg + XLEN'(4);
               end
            end
         end
         JWAIT:   state_next = JWAIT;
         DROP:    if (imem_rsp_valid_i) state_next = REQ;
         default: state_next = IDLE;
      endcase

      // A response still owed by memory must be swallowed before fetching the target.
      if (ex_redirect_i) begin
         fetch_pc_next = ex_redirect_pc_i;
         if (((state_reg == WAIT || state_reg == DROP) && !imem_rsp_valid_i) ||
             (state_reg == REQ && req_fire))
            state_next = DROP;
         else
            state_next = REQ;
      end
   end

   if_slot #(.XLEN(XLEN)) u_slot (
      .clk        (clk_i),
      .srst       (rst_i),
      .load       (rsp_load),
      .flush      (ex_redirect_i),
      .consume    (id_ready_i),
      .ld_instr   (imem_rsp_instr_i),
      .ld_pc      (fetch_pc_reg),
      .ld_pred    (rsp_pred),
      .valid      (if_valid_o),
      .instr      (if_instr_o),
      .pc         (if_pc_o),
      .pred_taken (if_pred_taken_o)
   );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Random-stimulus bench for if_fetch_ctrl: a memory model, a program-order walk
// feeding an expectation queue, and a monitor that checks every instruction ID takes.
module tb_if_fetch_ctrl;
   localparam logic [31:0] RST_PC  = 32'h8000_0000;
   localparam logic [6:0]  OP_JAL  = 7'b1101111;
   localparam logic [6:0]  OP_JALR = 7'b1100111;
   localparam logic [6:0]  OP_BR   = 7'b1100011;
   localparam logic [6:0]  OP_NOP  = 7'b0010011;
   localparam int          NCYC    = 3000;

   logic        clk, rst;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_instr, mdec_instr, mdec_imm;
   logic        mdec_jal, mdec_jalr, mdec_branch;
   logic        ex_redirect, id_ready;
   logic [31:0] ex_redirect_pc;
   logic        if_valid, if_pred_taken;
   logic [31:0] if_instr, if_pc;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
      logic        is_jalr;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0, bad = 0, consumed = 0;
   logic [31:0] walk_pc;
   logic        walk_stalled, jalr_pending;
   int          jalr_delay;
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_cnt;

   if_fetch_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .imem_req_valid_o (imem_req_valid),
      .imem_req_ready_i (imem_req_ready),
      .imem_req_addr_o  (imem_req_addr),
      .imem_rsp_valid_i (imem_rsp_valid),
      .imem_rsp_instr_i (imem_rsp_instr),
      .mdec_instr_o     (mdec_instr),
      .mdec_jal_i       (mdec_jal),
      .mdec_jalr_i      (mdec_jalr),
      .mdec_branch_i    (mdec_branch),
      .mdec_imm_i       (mdec_imm),
      .ex_redirect_i    (ex_redirect),
      .ex_redirect_pc_i (ex_redirect_pc),
      .id_ready_i       (id_ready),
      .if_valid_o       (if_valid),
      .if_instr_o       (if_instr),
      .if_pc_o          (if_pc),
      .if_pred_taken_o  (if_pred_taken)
   );

   // Stand-in mini decoder: word-scaled 12-bit immediate in instr[31:20].
   assign mdec_jal    = (mdec_instr[6:0] == OP_JAL);
   assign mdec_jalr   = (mdec_instr[6:0] == OP_JALR);
   assign mdec_branch = (mdec_instr[6:0] == OP_BR);
   assign mdec_imm    = {{18{mdec_instr[31]}}, mdec_instr[31:20], 2'b00};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Deterministic program image: the word at an address is a hash of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      logic [6:0]  op;
      h = a * 32'h9E37_79B1;
      h = h ^ (h >> 15);
      case (h[31:28])
         4'd0, 4'd1:             op = OP_JAL;
         4'd2:                   op = OP_JALR;
         4'd3, 4'd4, 4'd5, 4'd6: op = OP_BR;
         default:                op = OP_NOP;
      endcase
      return {{7{h[12]}}, h[12:8], h[24:12], op};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Next architectural fetch in program order; stalls after a jalr until EX redirects.
   task automatic walk_push();
      exp_t        e;
      logic [31:0] imm;
      e.pc      = walk_pc;
      e.instr   = mem_word(walk_pc);
      imm       = {{18{e.instr[31]}}, e.instr[31:20], 2'b00};
      e.is_jalr = (e.instr[6:0] == OP_JALR);
      e.pred    = (e.instr[6:0] == OP_JAL) || (e.instr[6:0] == OP_BR && $signed(imm) < 0);
      exp_q.push_back(e);
      if (e.is_jalr) walk_stalled = 1'b1;
      else           walk_pc = e.pred ? walk_pc + imm : walk_pc + 32'd4;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_instr = '0;
      ex_redirect = 1'b0; ex_redirect_pc = '0; id_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      chk("rst_if_valid", 32'(if_valid), 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, 0);
      chk("rst_if_pred", 32'(if_pred_taken), 0);
      exp_q.delete();
      walk_pc = RST_PC; walk_stalled = 1'b0; jalr_pending = 1'b0; jalr_delay = 0;
      mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
      rst = 1'b0;
      #1 chk("idle_no_req", 32'(imem_req_valid), 0);
   endtask

   // Stimulus: memory model, ID back-pressure, redirects; pushes expectations on acceptance.
   initial begin
      int  hold_cnt;
      logic rsp_now, acc, redir;
      hold_cnt = 0;
      do_reset();
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (cyc == NCYC / 2) begin
            do_reset();
            @(negedge clk);
         end
         rsp_now = 1'b0;
         if (mem_busy) begin
            if (mem_cnt == 0) rsp_now = 1'b1;
            else              mem_cnt--;
         end
         imem_rsp_valid = rsp_now;
         imem_rsp_instr = rsp_now ? mem_word(mem_addr) : $urandom;
         imem_req_ready = ($urandom % 10) < 7;
         if (hold_cnt > 0) begin
            id_ready = 1'b0;
            hold_cnt--;
         end else begin
            id_ready = ($urandom % 4) != 0;
            if ($urandom % 50 == 0) hold_cnt = 5;
         end
         redir = 1'b0;
         if (cyc > 4) begin
            if (jalr_pending) begin
               if (jalr_delay == 0) redir = 1'b1;
               else                 jalr_delay--;
            end else if ($urandom % 40 == 0) begin
               redir = 1'b1;
            end
         end
         ex_redirect    = redir;
         ex_redirect_pc = RST_PC + 32'(($urandom % 1024) << 2);
         #1;
         acc = imem_req_valid && imem_req_ready;
         if (acc) begin
            chk("one_outstanding", 32'(mem_busy), 0);
            chk("no_req_after_jalr", 32'(walk_stalled), 0);
            if (!walk_stalled) begin
               chk("req_addr", imem_req_addr, walk_pc);
               walk_push();
            end
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = $urandom % 3;
         end else if (rsp_now) begin
            mem_busy = 1'b0;
         end
         if (redir) begin
            exp_q.delete();
            walk_pc      = ex_redirect_pc;
            walk_stalled = 1'b0;
            jalr_pending = 1'b0;
         end
      end
      @(negedge clk);
      chk("consumed_enough", 32'(consumed > 300), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Monitor: every instruction ID takes must be the next expected one.
   always @(negedge clk) begin
      exp_t e;
      int   idle;
      #2;
      if (rst) begin
         idle = 0;
      end else begin
         if (if_valid && !id_ready) chk("stall_gate", 32'(imem_req_valid), 0);
         if (if_valid && id_ready && !ex_redirect) begin
            idle = 0;
            consumed++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL slot_unexpected actual_pc=%h required=none", if_pc);
            end else begin
               e = exp_q.pop_front();
               chk("slot_pc", if_pc, e.pc);
               chk("slot_instr", if_instr, e.instr);
               chk("slot_pred", 32'(if_pred_taken), 32'(e.pred));
               if (e.is_jalr) begin
                  jalr_pending = 1'b1;
                  jalr_delay   = $urandom % 4;
               end
            end
         end else begin
            idle++;
            if (idle == 400) begin
               total++;
               bad++;
               $display("FAIL liveness actual=no_slot_for_400_cycles required=progress");
               idle = 0;
            end
         end
      end
   end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage sequencer for the pipelined RV32 core.
- Generates the fetch PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Passes each returned instruction through the IF mini decoder, which reports jal/jalr/branch plus imm, and chooses the next PC using static prediction.
- Holds the fetched instruction in a one-entry skid slot toward ID, and handles EX redirects and drains in-flight responses.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  fetch address
- imem_rsp_valid_i  in  1  instruction returned (one cycle pulse, in order)
- imem_rsp_instr_i  in  32  returned instruction
- mdec_instr_o  out  32  instruction to mini decoder (imem_rsp_instr_i, combinational)
- mdec_jal_i  in  1  mini-decoder jal
- mdec_jalr_i  in  1  mini-decoder jalr
- mdec_branch_i  in  1  mini-decoder conditional branch
- mdec_imm_i  in  XLEN  mini-decoder immediate
- ex_redirect_i  in  1  EX mispredict/jalr/trap redirect
- ex_redirect_pc_i  in  XLEN  redirect target
- id_ready_i  in  1  ID accepts slot this cycle
- if_valid_o  out  1  slot holds valid instruction
- if_instr_o  out  32  slot instruction
- if_pc_o  out  XLEN  slot PC
- if_pred_taken_o  out  1  slot predicted taken (jal or backward branch)

Behaviour:
- Reset: state IDLE; fetch_pc=RESET_PC; imem_req_valid_o=0, imem_req_addr_o=RESET_PC; if_valid_o=0, if_instr_o=0, if_pc_o=0, if_pred_taken_o=0; drop flag cleared.
- FSM states: IDLE, REQ, WAIT, JWAIT, DROP.
- IDLE -> REQ the cycle after reset deasserts.
- REQ:
  - imem_req_valid_o=1 and imem_req_addr_o=fetch_pc, held stable until accepted.
  - Request is presented only when the slot is empty or is consumed this cycle (if_valid_o & id_ready_i); otherwise valid=0 and the FSM stays in REQ.
  - valid&ready -> WAIT.
- WAIT, on imem_rsp_valid_i:
  - Slot loads {instr, pc=fetch_pc, pred}. The response path never has the slot full, by the REQ gating rule.
  - jal: next=fetch_pc+imm, pred=1 -> REQ.
  - branch with imm[XLEN-1]=1: next=fetch_pc+imm, pred=1 -> REQ.
  - Forward branch or other instruction: next=fetch_pc+4, pred=0 -> REQ.
  - jalr: pred=0 -> JWAIT. No fetch is issued until a redirect arrives.
- JWAIT: waits for ex_redirect_i.
- Adders are modulo 2^XLEN; wrap-around is silent. Target alignment is not checked here; EX raises misalignment.
- Slot: if_valid_o is cleared when id_ready_i=1 and no new load occurs in the same cycle. Load and consume in the same cycle leaves the slot valid with the new contents.
- Redirect (highest priority, any state):
  - fetch_pc=ex_redirect_pc_i and the slot is invalidated in the same cycle.
  - In WAIT, or in REQ with the request accepted that cycle: -> DROP. The next imem_rsp_valid_i is discarded (no slot load, no mdec use), then -> REQ.
  - Otherwise: -> REQ, and the new address appears on imem_req_addr_o the next cycle.
  - A second redirect while in DROP updates fetch_pc and stays in DROP.
  - A redirect coinciding with imem_rsp_valid_i in WAIT discards that response and goes directly to REQ.
- Latency: minimum response latency 1 cycle. Request-to-slot-valid is rsp latency + 1 cycle. At most one outstanding request.
- Reset mid-operation: immediate return to the reset state. The memory side is reset by the same rst_i, so no stale response arrives.

Decomposition:
- Shared defines (existing defines header): XLEN, INSTR_WIDTH, RESET_PC default, and fetch FSM state encodings (3-bit localparams).
- Sub-module if_slot: one-entry pipeline register with load/consume/flush; the FSM and next-PC logic stay in the top.
- if_mini_dec is instantiated by the IF stage top, not inside this block.

Test Plan:
- Reset release, imem ready=1, latency 1, straight-line NOPs, id_ready_i=1 -> addrs 0x80000000, 0x80000004, 0x80000008; if_pc_o follows, pred=0.
- jal imm=0x100 at 0x80000000 -> next req addr 0x80000100; slot pred_taken=1.
- Branch imm=-8 at 0x80000010 -> next addr 0x80000008, pred=1; branch imm=+8 -> 0x80000014, pred=0.
- jalr at 0x80000020 -> no requests for 10 cycles; ex_redirect_i with pc 0x80000400 -> next req addr 0x80000400.
- Redirect to 0x80001000 one cycle after request acceptance, response latency 3 -> that response dropped (if_valid_o stays 0); next req addr 0x80001000.
- id_ready_i=0 for 5 cycles with slot full -> imem_req_valid_o=0 and slot held stable; releasing id_ready_i -> request issued the same cycle.
